// File: rtl/br_checkpoint_stack_nw.sv
// N-wide branch checkpoint stack: one-hot ids, rename-map snapshots with CDB-tracked ready bits.
// Optional BR_CHECKPOINT_STATS_EN adds saturating alloc/squash/stall counters.
module br_checkpoint_stack_nw #(
    parameter int DEPTH     = 8,
    parameter int DISP_W    = 2,
    parameter int CDB_N     = 2,
    parameter int ARCH_REGS = 32,
    parameter int PREG_W    = 6,
    parameter int SIDE_W    = 48
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [DISP_W-1:0]                   alloc_req,
    input  logic [DISP_W*ARCH_REGS*PREG_W-1:0]  alloc_mt,
    input  logic [DISP_W*ARCH_REGS-1:0]         alloc_rdy,
    input  logic [DISP_W*SIDE_W-1:0]            alloc_side,
    output logic [DISP_W-1:0]                   alloc_gnt,
    output logic [DISP_W*DEPTH-1:0]             alloc_id,
    output logic [DISP_W*DEPTH-1:0]             alloc_mask,
    input  logic                                res_valid,
    input  logic                                res_squash,
    input  logic [DEPTH-1:0]                    res_id,
    input  logic [CDB_N-1:0]                    cdb_valid,
    input  logic [CDB_N*PREG_W-1:0]             cdb_tag,
    output logic                                cp_valid,
    output logic [ARCH_REGS*PREG_W-1:0]         cp_mt,
    output logic [ARCH_REGS-1:0]                cp_rdy,
    output logic [SIDE_W-1:0]                   cp_side,
    output logic [DEPTH-1:0]                    live_mask,
    output logic [$clog2(DEPTH+1)-1:0]          free_cnt,
    output logic                                full
`ifdef BR_CHECKPOINT_STATS_EN
    ,
    output logic [31:0]                         stat_alloc,
    output logic [31:0]                         stat_squash,
    output logic [31:0]                         stat_stall
`endif
);
    localparam int MT_W   = ARCH_REGS * PREG_W;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int SLOT_W = (DISP_W > 1) ? $clog2(DISP_W) : 1;

    logic                 entry_valid_reg [DEPTH];
    logic [DEPTH-1:0]     mask_reg        [DEPTH];
    logic [MT_W-1:0]      mt_reg          [DEPTH];
    logic [ARCH_REGS-1:0] rdy_reg         [DEPTH];
    logic [SIDE_W-1:0]    side_reg        [DEPTH];

    logic [DEPTH-1:0]     live_vec;
    logic [ARCH_REGS-1:0] rdy_upd       [DEPTH];
    logic [ARCH_REGS-1:0] alloc_rdy_fwd [DISP_W];
    logic [DEPTH-1:0]     slot_id       [DISP_W];
    logic [DEPTH-1:0]     slot_mask     [DISP_W];
    logic [DEPTH-1:0]     wr_en;
    logic [SLOT_W-1:0]    wr_slot       [DEPTH];
    logic [DEPTH-1:0]     res_hit_vec;
    logic [DEPTH-1:0]     live_eff;
    logic                 do_clear;
    logic                 do_squash;
    logic                 alloc_blocked;

    // Tag 0 is the hardwired-ready register and never matches a broadcast.
    function automatic logic tag_hit(input logic [PREG_W-1:0] tag,
                                     input logic [CDB_N-1:0] v,
                                     input logic [CDB_N*PREG_W-1:0] tags);
        logic h;
        h = 1'b0;
        for (int c = 0; c < CDB_N; c++)
            if (v[c] && (tags[c*PREG_W +: PREG_W] == tag))
                h = 1'b1;
        return h && (tag != '0);
    endfunction

    genvar gi, gk;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign live_vec[gi] = entry_valid_reg[gi];
            always_comb begin
                rdy_upd[gi] = rdy_reg[gi];
                for (int r = 0; r < ARCH_REGS; r++)
                    if (tag_hit(mt_reg[gi][r*PREG_W +: PREG_W], cdb_valid, cdb_tag))
                        rdy_upd[gi][r] = 1'b1;
            end
        end
        for (gk = 0; gk < DISP_W; gk++) begin : g_slot
            always_comb begin
                alloc_rdy_fwd[gk] = alloc_rdy[gk*ARCH_REGS +: ARCH_REGS];
                for (int r = 0; r < ARCH_REGS; r++)
                    if (tag_hit(alloc_mt[(gk*ARCH_REGS + r)*PREG_W +: PREG_W], cdb_valid, cdb_tag))
                        alloc_rdy_fwd[gk][r] = 1'b1;
            end
            assign alloc_id[gk*DEPTH +: DEPTH]   = slot_id[gk];
            assign alloc_mask[gk*DEPTH +: DEPTH] = slot_mask[gk];
        end
    endgenerate

    // Grant lowest free entries to oldest requesting slots; stop at the first denial.
    always_comb begin
        logic [DEPTH-1:0] avail;
        logic [DEPTH-1:0] run;
        logic [DEPTH-1:0] sel;
        logic             denied;
        res_hit_vec   = res_id & live_vec;
        do_clear      = !reset && res_valid && !res_squash && (|res_hit_vec);
        do_squash     = !reset && res_valid && res_squash && (|res_hit_vec);
        alloc_blocked = reset || (res_valid && res_squash);
        live_eff      = do_clear ? (live_vec & ~res_id) : live_vec;
        avail         = ~live_eff;
        run           = live_eff;
        sel           = '0;
        denied        = 1'b0;
        alloc_gnt     = '0;
        wr_en         = '0;
        for (int k = 0; k < DISP_W; k++) begin
            slot_id[k]   = '0;
            slot_mask[k] = '0;
        end
        for (int i = 0; i < DEPTH; i++)
            wr_slot[i] = '0;
        for (int k = 0; k < DISP_W; k++) begin
            if (alloc_req[k] && !alloc_blocked && !denied) begin
                sel = avail & (~avail + DEPTH'(1));
                if (|sel) begin
                    alloc_gnt[k] = 1'b1;
                    slot_id[k]   = sel;
                    slot_mask[k] = run | sel;
                    run          = run | sel;
                    avail        = avail & ~sel;
                    wr_en        = wr_en | sel;
                    for (int i = 0; i < DEPTH; i++)
                        if (sel[i])
                            wr_slot[i] = SLOT_W'(k);
                end else begin
                    denied = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_valid_reg[i] <= 1'b0;
                mask_reg[i]        <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) begin
                    entry_valid_reg[i] <= 1'b1;
                    mask_reg[i]        <= slot_mask[wr_slot[i]];
                    mt_reg[i]          <= alloc_mt[wr_slot[i]*MT_W +: MT_W];
                    rdy_reg[i]         <= alloc_rdy_fwd[wr_slot[i]];
                    side_reg[i]        <= alloc_side[wr_slot[i]*SIDE_W +: SIDE_W];
                end else begin
                    // Squash kills the target and every younger dependent in one step.
                    if ((do_squash && (|(mask_reg[i] & res_id))) || (do_clear && res_id[i]))
                        entry_valid_reg[i] <= 1'b0;
                    if (do_clear)
                        mask_reg[i] <= mask_reg[i] & ~res_id;
                    rdy_reg[i] <= rdy_upd[i];
                end
            end
        end
    end

    always_comb begin
        cp_valid = do_squash;
        cp_mt    = '0;
        cp_rdy   = '0;
        cp_side  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (do_squash && res_hit_vec[i]) begin
                cp_mt   = cp_mt | mt_reg[i];
                cp_rdy  = cp_rdy | rdy_upd[i];
                cp_side = cp_side | side_reg[i];
            end
        end
    end

    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < DEPTH; i++)
            if (!live_vec[i])
                free_cnt = free_cnt + CNT_W'(1);
    end

    assign live_mask = live_vec;
    assign full      = (free_cnt == '0);

`ifdef BR_CHECKPOINT_STATS_EN
    logic [31:0] gnt_cnt;
    logic        stall_cycle;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

    always_comb begin
        gnt_cnt = '0;
        for (int k = 0; k < DISP_W; k++)
            if (alloc_gnt[k])
                gnt_cnt = gnt_cnt + 32'd1;
        stall_cycle = |(alloc_req & ~alloc_gnt);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stat_alloc  <= '0;
            stat_squash <= '0;
            stat_stall  <= '0;
        end else begin
            stat_alloc  <= sat_add(stat_alloc, gnt_cnt);
            stat_squash <= sat_add(stat_squash, {31'd0, do_squash});
            stat_stall  <= sat_add(stat_stall, {31'd0, stall_cycle});
        end
    end
`endif

endmodule

// File: tb/tb_br_checkpoint_stack_nw.sv
// Scoreboard bench for br_checkpoint_stack_nw: directed cycles push expectations, a negedge monitor checks them.
module tb_br_checkpoint_stack_nw;
    logic         clock;
    logic         reset;
    logic [1:0]   alloc_req;
    logic [383:0] alloc_mt;
    logic [63:0]  alloc_rdy;
    logic [95:0]  alloc_side;
    logic [1:0]   alloc_gnt;
    logic [15:0]  alloc_id;
    logic [15:0]  alloc_mask;
    logic         res_valid;
    logic         res_squash;
    logic [7:0]   res_id;
    logic [1:0]   cdb_valid;
    logic [11:0]  cdb_tag;
    logic         cp_valid;
    logic [191:0] cp_mt;
    logic [31:0]  cp_rdy;
    logic [47:0]  cp_side;
    logic [7:0]   live_mask;
    logic [3:0]   free_cnt;
    logic         full;

    br_checkpoint_stack_nw dut (
        .clock(clock), .reset(reset),
        .alloc_req(alloc_req), .alloc_mt(alloc_mt), .alloc_rdy(alloc_rdy), .alloc_side(alloc_side),
        .alloc_gnt(alloc_gnt), .alloc_id(alloc_id), .alloc_mask(alloc_mask),
        .res_valid(res_valid), .res_squash(res_squash), .res_id(res_id),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cp_valid(cp_valid), .cp_mt(cp_mt), .cp_rdy(cp_rdy), .cp_side(cp_side),
        .live_mask(live_mask), .free_cnt(free_cnt), .full(full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [1:0]  gnt;
        logic [15:0] id;
        logic [15:0] mask;
        logic        cpv;
        logic [47:0] side;
        logic [31:0] rdy;
        logic [7:0]  live;
        logic [3:0]  fc;
        logic        fl;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int total = 0;
    int bad   = 0;

    function automatic logic [47:0] sd(input int n);
        return 48'h5A00_0000_0000 + 48'(n);
    endfunction

    function automatic logic [191:0] mt5(input logic [5:0] t);
        logic [191:0] m;
        m = '0;
        m[35:30] = t;
        return m;
    endfunction

    task automatic chk(input string nm, input string fld, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            $display("txn %s: gnt=%b id=%h mask=%h cpv=%b side=%h rdy=%h live=%h free=%0d full=%b",
                     e.name, alloc_gnt, alloc_id, alloc_mask, cp_valid, cp_side, cp_rdy,
                     live_mask, free_cnt, full);
            chk(e.name, "gnt", 64'(alloc_gnt), 64'(e.gnt));
            chk(e.name, "id", 64'(alloc_id), 64'(e.id));
            chk(e.name, "mask", 64'(alloc_mask), 64'(e.mask));
            chk(e.name, "cp_valid", 64'(cp_valid), 64'(e.cpv));
            chk(e.name, "cp_side", 64'(cp_side), 64'(e.side));
            chk(e.name, "cp_rdy", 64'(cp_rdy), 64'(e.rdy));
            chk(e.name, "live", 64'(live_mask), 64'(e.live));
            chk(e.name, "free_cnt", 64'(free_cnt), 64'(e.fc));
            chk(e.name, "full", 64'(full), 64'(e.fl));
        end
    end

    task automatic drv(input logic rst, input logic [1:0] req, input logic rv, input logic rsq,
                       input logic [7:0] rid, input logic [1:0] cv, input logic [5:0] t0, input logic [5:0] t1);
        reset      = rst;
        alloc_req  = req;
        res_valid  = rv;
        res_squash = rsq;
        res_id     = rid;
        cdb_valid  = cv;
        cdb_tag    = {t1, t0};
    endtask

    task automatic expect_cyc(input string nm, input logic [1:0] gnt, input logic [15:0] id,
                              input logic [15:0] mask, input logic cpv, input logic [47:0] side,
                              input logic [31:0] rdy, input logic [7:0] live, input logic [3:0] fc,
                              input logic fl);
        exp_t x;
        x.name = nm; x.gnt = gnt; x.id = id; x.mask = mask; x.cpv = cpv;
        x.side = side; x.rdy = rdy; x.live = live; x.fc = fc; x.fl = fl;
        q.push_back(x);
        @(posedge clock);
        #1;
    endtask

    initial begin
        alloc_mt   = '0;
        alloc_rdy  = '0;
        alloc_side = '0;
        drv(1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 6'd0, 6'd0);
        @(posedge clock);
        #1;

        // Reset state, requests suppressed while reset is held
        drv(1'b1, 2'b11, 1'b0, 1'b0, 8'h00, 2'b00, 6'd0, 6'd0);
        expect_cyc("reset", 2'b00, 16'h0000, 16'h0000, 1'b0, 48'h0, 32'h0, 8'h00, 4'd8, 1'b0);

        // Fill the stack two at a time
        alloc_side = {sd(2), sd(1)};
        drv(1'b0, 2'b11, 1'b0, 1'b0, 8'h00, 2'b00, 6'd0, 6'd0);
        expect_cyc("alloc_01_02", 2'b11, 16'h0201, 16'h0301, 1'b0, 48'h0, 32'h0, 8'h00, 4'd8, 1'b0);
        alloc_side = {sd(4), sd(3)};
        expect_cyc("alloc_04_08", 2'b11, 16'h0804, 16'h0F07, 1'b0, 48'h0, 32'h0, 8'h03, 4'd6, 1'b0);
        expect_cyc("alloc_10_20", 2'b11, 16'h2010, 16'h3F1F, 1'b0, 48'h0, 32'h0, 8'h0F, 4'd4, 1'b0);
        expect_cyc("alloc_40_80", 2'b11, 16'h8040, 16'hFF7F, 1'b0, 48'h0, 32'h0, 8'h3F, 4'd2, 1'b0);
        expect_cyc("full_deny", 2'b00, 16'h0000, 16'h0000, 1'b0, 48'h0, 32'h0, 8'hFF, 4'd0, 1'b1);
        drv(1'b0, 2'b00, 1'b1, 1'b0, 8'h80, 2'b00, 6'd0, 6'd0);
        expect_cyc("clear_80", 2'b00, 16'h0000, 16'h0000, 1'b0, 48'h0, 32'h0, 8'hFF, 4'd0, 1'b1);
        drv(1'b0, 2'b11, 1'b0, 1'b0, 8'h00, 2'b00, 6'd0, 6'd0);
        expect_cyc("prefix_one_free", 2'b01, 16'h0080, 16'h00FF, 1'b0, 48'h0, 32'h0, 8'h7F, 4'd1, 1'b0);
        drv(1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 6'd0, 6'd0);
        expect_cyc("reset_full", 2'b00, 16'h0000, 16'h0000, 1'b0, 48'h0, 32'h0, 8'hFF, 4'd0, 1'b1);

        // Squash of a middle entry takes its dependents with it
        alloc_side = {sd(2), sd(1)};
        drv(1'b0, 2'b11, 1'b0, 1'b0, 8'h00, 2'b00, 6'd0, 6'd0);
        expect_cyc("sq_alloc_01_02", 2'b11, 16'h0201, 16'h0301, 1'b0, 48'h0, 32'h0, 8'h00, 4'd8, 1'b0);
        alloc_side = {sd(0), sd(3)};
        drv(1'b0, 2'b01, 1'b0, 1'b0, 8'h00, 2'b00, 6'd0, 6'd0);
        expect_cyc("sq_alloc_04", 2'b01, 16'h0004, 16'h0007, 1'b0, 48'h0, 32'h0, 8'h03, 4'd6, 1'b0);
        drv(1'b0, 2'b01, 1'b1, 1'b1, 8'h02, 2'b00, 6'd0, 6'd0);
        expect_cyc("squash_02", 2'b00, 16'h0000, 16'h0000, 1'b1, sd(2), 32'h0, 8'h07, 4'd5, 1'b0);
        drv(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 6'd0, 6'd0);
        expect_cyc("after_squash", 2'b00, 16'h0000, 16'h0000, 1'b0, 48'h0, 32'h0, 8'h01, 4'd7, 1'b0);

        // Clear and reallocate the same id in one cycle
        alloc_side = {sd(0), sd(4)};
        drv(1'b0, 2'b01, 1'b0, 1'b0, 8'h00, 2'b00, 6'd0, 6'd0);
        expect_cyc("cl_alloc_02", 2'b01, 16'h0002, 16'h0003, 1'b0, 48'h0, 32'h0, 8'h01, 4'd7, 1'b0);
        alloc_side = {sd(0), sd(5)};
        drv(1'b0, 2'b01, 1'b1, 1'b0, 8'h01, 2'b00, 6'd0, 6'd0);
        expect_cyc("clear_realloc_01", 2'b01, 16'h0001, 16'h0003, 1'b0, 48'h0, 32'h0, 8'h03, 4'd6, 1'b0);
        drv(1'b0, 2'b00, 1'b1, 1'b1, 8'h01, 2'b00, 6'd0, 6'd0);
        expect_cyc("squash_new_01", 2'b00, 16'h0000, 16'h0000, 1'b1, sd(5), 32'h0, 8'h03, 4'd6, 1'b0);
        drv(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 6'd0, 6'd0);
        expect_cyc("mask_02_kept", 2'b00, 16'h0000, 16'h0000, 1'b0, 48'h0, 32'h0, 8'h02, 4'd7, 1'b0);

        // CDB wakeup of a stored snapshot
        alloc_mt   = {192'd0, mt5(6'd9)};
        alloc_side = {sd(0), sd(6)};
        drv(1'b0, 2'b01, 1'b0, 1'b0, 8'h00, 2'b00, 6'd0, 6'd0);
        expect_cyc("cdb_alloc", 2'b01, 16'h0001, 16'h0003, 1'b0, 48'h0, 32'h0, 8'h02, 4'd7, 1'b0);
        drv(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 2'b01, 6'd9, 6'd0);
        expect_cyc("cdb_bcast_9", 2'b00, 16'h0000, 16'h0000, 1'b0, 48'h0, 32'h0, 8'h03, 4'd6, 1'b0);
        drv(1'b0, 2'b00, 1'b1, 1'b1, 8'h01, 2'b00, 6'd0, 6'd0);
        expect_cyc("cdb_restore", 2'b00, 16'h0000, 16'h0000, 1'b1, sd(6), 32'h0000_0020, 8'h03, 4'd6, 1'b0);

        // Broadcast in the allocate cycle is written through
        alloc_side = {sd(0), sd(7)};
        drv(1'b0, 2'b01, 1'b0, 1'b0, 8'h00, 2'b10, 6'd0, 6'd9);
        expect_cyc("wt_alloc", 2'b01, 16'h0001, 16'h0003, 1'b0, 48'h0, 32'h0, 8'h02, 4'd7, 1'b0);
        drv(1'b0, 2'b00, 1'b1, 1'b1, 8'h01, 2'b00, 6'd0, 6'd0);
        expect_cyc("wt_restore", 2'b00, 16'h0000, 16'h0000, 1'b1, sd(7), 32'h0000_0020, 8'h03, 4'd6, 1'b0);

        // Tag 0 broadcasts never set ready
        alloc_mt   = '0;
        alloc_side = {sd(0), sd(8)};
        drv(1'b0, 2'b01, 1'b0, 1'b0, 8'h00, 2'b01, 6'd0, 6'd0);
        expect_cyc("tag0_alloc", 2'b01, 16'h0001, 16'h0003, 1'b0, 48'h0, 32'h0, 8'h02, 4'd7, 1'b0);
        drv(1'b0, 2'b00, 1'b1, 1'b1, 8'h01, 2'b01, 6'd0, 6'd0);
        expect_cyc("tag0_restore", 2'b00, 16'h0000, 16'h0000, 1'b1, sd(8), 32'h0, 8'h03, 4'd6, 1'b0);

        // Broadcast in the squash cycle forwards into cp_rdy
        alloc_mt   = {192'd0, mt5(6'd9)};
        alloc_side = {sd(0), sd(9)};
        drv(1'b0, 2'b01, 1'b0, 1'b0, 8'h00, 2'b00, 6'd0, 6'd0);
        expect_cyc("fwd_alloc", 2'b01, 16'h0001, 16'h0003, 1'b0, 48'h0, 32'h0, 8'h02, 4'd7, 1'b0);
        drv(1'b0, 2'b00, 1'b1, 1'b1, 8'h01, 2'b10, 6'd0, 6'd9);
        expect_cyc("fwd_restore", 2'b00, 16'h0000, 16'h0000, 1'b1, sd(9), 32'h0000_0020, 8'h03, 4'd6, 1'b0);

        // Squash of a non-live id does nothing
        alloc_mt = '0;
        drv(1'b0, 2'b00, 1'b1, 1'b1, 8'h80, 2'b00, 6'd0, 6'd0);
        expect_cyc("squash_nonlive", 2'b00, 16'h0000, 16'h0000, 1'b0, 48'h0, 32'h0, 8'h02, 4'd7, 1'b0);
        drv(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 6'd0, 6'd0);
        expect_cyc("nonlive_after", 2'b00, 16'h0000, 16'h0000, 1'b0, 48'h0, 32'h0, 8'h02, 4'd7, 1'b0);

        // Reset in the middle of an allocation
        drv(1'b1, 2'b11, 1'b0, 1'b0, 8'h00, 2'b00, 6'd0, 6'd0);
        expect_cyc("reset_mid_alloc", 2'b00, 16'h0000, 16'h0000, 1'b0, 48'h0, 32'h0, 8'h02, 4'd7, 1'b0);
        drv(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 6'd0, 6'd0);
        expect_cyc("post_reset", 2'b00, 16'h0000, 16'h0000, 1'b0, 48'h0, 32'h0, 8'h00, 4'd8, 1'b0);

        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(posedge clock);
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/br_checkpoint_stack_nw.md
Name: br_checkpoint_stack_nw

Overview:
N-wide successor to the single-dispatch branch checkpoint stack. It allocates up to DISP_W branch checkpoints per cycle in one-hot branch-id form. Each checkpoint captures a rename map snapshot with ready bits, plus opaque side data (free-list head, ROB/SQ tails, BHR, prediction). It resolves one branch per cycle (clear or squash), tracks per-entry dependency masks, and keeps snapshot ready bits current from N CDB channels. Sits between decode/rename and the branch-resolution unit.

Parameters:
DEPTH, 8, number of checkpoints; branch ids are one-hot DEPTH bits
DISP_W, 2, branch allocation slots per cycle
CDB_N, 2, CDB broadcast channels
ARCH_REGS, 32, architectural registers per snapshot
PREG_W, 6, physical register tag width
SIDE_W, 48, opaque side-data width per checkpoint

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
alloc_req  in  DISP_W  per-slot branch allocate request; slot 0 is oldest
alloc_mt  in  DISP_W*ARCH_REGS*PREG_W  per-slot map snapshot tags
alloc_rdy  in  DISP_W*ARCH_REGS  per-slot snapshot ready bits
alloc_side  in  DISP_W*SIDE_W  per-slot side data
alloc_gnt  out  DISP_W  slot granted this cycle
alloc_id  out  DISP_W*DEPTH  one-hot id per granted slot, 0 if not granted
alloc_mask  out  DISP_W*DEPTH  dependency mask per granted slot
res_valid  in  1  resolve this cycle
res_squash  in  1  1 = mispredict squash, 0 = correct-predict clear
res_id  in  DEPTH  one-hot id being resolved
cdb_valid  in  CDB_N  channel valid
cdb_tag  in  CDB_N*PREG_W  completed physical tag
cp_valid  out  1  restore data valid (squash hit a live entry)
cp_mt  out  ARCH_REGS*PREG_W  restored map tags
cp_rdy  out  ARCH_REGS  restored ready bits, CDB-forwarded
cp_side  out  SIDE_W  restored side data
live_mask  out  DEPTH  ids currently allocated
free_cnt  out  $clog2(DEPTH+1)  free entries
full  out  1  free_cnt == 0

Behaviour:
- Reset: every entry invalid and free. live_mask=0, free_cnt=DEPTH, full=0. All alloc_* outputs and cp_* outputs are 0. Reset takes priority over all same-cycle requests and drops any in-flight allocate or resolve.
- Free entries are granted in ascending index order, to requesting slots in ascending slot order.
- If fewer entries are free than requests, only the oldest requesting slots are granted. A slot is never granted when an older requesting slot was denied (prefix rule).
- Grant outputs are combinational from the current state and this cycle's resolve. Entry state updates on the next clock edge.
- A clear frees its entry in the same cycle, and that entry is grantable in that same cycle.
- Dependency mask for granted slot k = live_mask (after this cycle's clear) | ids granted to slots j<k | slot k's own id.
- Clear (res_valid & !res_squash): free the entry whose id == res_id, and remove res_id from every other entry's mask and from live_mask. A res_id that is not live is ignored. Same-cycle allocations proceed.
- Squash (res_valid & res_squash): cp_* is driven combinationally the same cycle from the entry with id == res_id, with cp_rdy including this cycle's CDB hits. That entry and every entry whose mask contains res_id are freed. All alloc_req are ignored that cycle (alloc_gnt=0). A squash on a non-live id gives cp_valid=0 and changes no state.
- CDB: for each valid channel, set the ready bit of every snapshot register whose tag == cdb_tag. This applies to stored entries and to entries being written this cycle (write-through). Tag 0 never sets ready.
- free_cnt and full reflect registered state only.

Optional Feature:
BR_CHECKPOINT_STATS_EN. When defined, it adds outputs stat_alloc (32), stat_squash (32) and stat_stall (32). These are saturating counters, reset to 0, counting granted slots, squashes that hit a live entry, and cycles with at least one denied request. When not defined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then alloc_req=2'b11 with DEPTH=8 -> alloc_id slot0=8'h01, slot1=8'h02; alloc_mask 8'h01 / 8'h03; next cycle live_mask=8'h03, free_cnt=6.
- Allocate 8 ids over 4 cycles, then alloc_req=2'b11 -> alloc_gnt=0, full=1. With 7 ids live, alloc_req=2'b11 -> alloc_gnt=2'b01.
- Ids 01,02,04 live (chained masks 01/03/07); squash 02 -> cp_valid=1, cp_side=entry 1 data; next cycle live_mask=8'h01. Same-cycle alloc_req=2'b01 -> alloc_gnt=0.
- Live 01,02; clear 01 plus alloc_req=2'b01 same cycle -> alloc_id=8'h01, alloc_mask=8'h03. Stored mask of id 02 becomes 8'h02.
- Entry snapshot has r5 tag 9, not ready; cdb_tag=9 broadcast -> squash later restores cp_rdy[5]=1. Broadcast coinciding with the allocate cycle is also captured.
- Squash with a non-live res_id=8'h80 -> cp_valid=0, live_mask unchanged. Reset asserted mid-allocation -> next cycle free_cnt=8, all outputs 0.
